// File: rtl/tour_pred_ctrl.sv
// Tournament chooser: CPHT + speculative GHR; prediction and flush request are combinational, state updates at clk.
// No backpressure; stallF only blocks the speculative GHR shift, and E-stage repair always wins over it.
module tour_pred_ctrl #(
    parameter int PHT_IDX_W = 10,
    parameter int GHR_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pcF,
    input  logic                 branchF,
    input  logic                 stallF,
    input  logic                 local_predF,
    input  logic                 global_predF,
    output logic                 predict_takenF,
    output logic                 choiceF,
    output logic [GHR_W-1:0]     ghrF,
    input  logic                 update_valid,
    input  logic [31:0]          pcE,
    input  logic [GHR_W-1:0]     ghrE,
    input  logic                 local_predE,
    input  logic                 global_predE,
    input  logic                 predictedE,
    input  logic                 actual_taken,
    output logic                 mispredictE,
    output logic                 ready,
    output logic [31:0]          br_count,
    output logic [31:0]          mispred_count
);

    localparam int ENTRIES = 1 << PHT_IDX_W;

    typedef enum logic {INIT, RUN} state_e;

    state_e                 state_q, state_d;
    logic [PHT_IDX_W-1:0]   init_idx_q, init_idx_d;
    logic [GHR_W-1:0]       ghr_q, ghr_d;
    logic [31:0]            br_cnt_q, br_cnt_d;
    logic [31:0]            mis_cnt_q, mis_cnt_d;

    logic [1:0]             cpht_q [ENTRIES];
    logic                   cpht_we;
    logic [PHT_IDX_W-1:0]   cpht_waddr;
    logic [1:0]             cpht_wdat;

    logic [PHT_IDX_W-1:0]   ghr_ext_f, ghr_ext_e;
    logic [PHT_IDX_W-1:0]   idx_f, idx_e;
    logic [1:0]             ctr_e;
    logic                   run;

    logic                   unused_pc_bits;
    assign unused_pc_bits = ^{pcF[31:PHT_IDX_W+2], pcF[1:0], pcE[31:PHT_IDX_W+2], pcE[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            ghr_q      <= '0;
            br_cnt_q   <= '0;
            mis_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ghr_q      <= ghr_d;
            br_cnt_q   <= br_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    // Table contents need no reset: INIT rewrites every entry before RUN.
    always_ff @(posedge clk) begin
        if (cpht_we) begin
            cpht_q[cpht_waddr] <= cpht_wdat;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == INIT) begin
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == {PHT_IDX_W{1'b1}}) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        run            = (state_q == RUN);
        ready          = run;
        ghr_ext_f      = '0;
        ghr_ext_f[GHR_W-1:0] = ghr_q;
        ghr_ext_e      = '0;
        ghr_ext_e[GHR_W-1:0] = ghrE;
        idx_f          = pcF[PHT_IDX_W+1:2] ^ ghr_ext_f;
        idx_e          = pcE[PHT_IDX_W+1:2] ^ ghr_ext_e;
        choiceF        = run & cpht_q[idx_f][1];
        predict_takenF = run & branchF & (choiceF ? global_predF : local_predF);
        mispredictE    = run & update_valid & (predictedE ^ actual_taken);
        ghrF           = ghr_q;
        br_count       = br_cnt_q;
        mispred_count  = mis_cnt_q;
    end

    always_comb begin
        ghr_d      = ghr_q;
        br_cnt_d   = br_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        cpht_we    = 1'b0;
        cpht_waddr = init_idx_q;
        cpht_wdat  = 2'b01;
        ctr_e      = cpht_q[idx_e];
        if (!run) begin
            cpht_we = 1'b1;
        end else begin
            if (mispredictE) begin
                ghr_d = {ghrE[GHR_W-2:0], actual_taken};
            end else if (branchF && !stallF) begin
                ghr_d = {ghr_q[GHR_W-2:0], predict_takenF};
            end
            if (update_valid && (br_cnt_q != 32'hFFFF_FFFF)) begin
                br_cnt_d = br_cnt_q + 32'd1;
            end
            if (mispredictE && (mis_cnt_q != 32'hFFFF_FFFF)) begin
                mis_cnt_d = mis_cnt_q + 32'd1;
            end
            // Chooser only learns when the two predictors disagreed.
            if (update_valid && (local_predE != global_predE)) begin
                cpht_we    = 1'b1;
                cpht_waddr = idx_e;
                if (global_predE == actual_taken) begin
                    cpht_wdat = (ctr_e == 2'b11) ? 2'b11 : ctr_e + 2'b01;
                end else begin
                    cpht_wdat = (ctr_e == 2'b00) ? 2'b00 : ctr_e - 2'b01;
                end
            end
        end
    end

endmodule

// File: tb/tb_tour_pred_ctrl.sv
// Directed bench for tour_pred_ctrl with a 16-entry CPHT and 4-bit GHR.
module tb_tour_pred_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF, pcE;
    logic        branchF, stallF, local_predF, global_predF;
    logic        predict_takenF, choiceF;
    logic [3:0]  ghrF, ghrE;
    logic        update_valid, local_predE, global_predE, predictedE, actual_taken;
    logic        mispredictE, ready;
    logic [31:0] br_count, mispred_count;

    int tests = 0;
    int fails = 0;

    tour_pred_ctrl #(.PHT_IDX_W(4), .GHR_W(4)) dut (
        .clk(clk), .rst(rst),
        .pcF(pcF), .branchF(branchF), .stallF(stallF),
        .local_predF(local_predF), .global_predF(global_predF),
        .predict_takenF(predict_takenF), .choiceF(choiceF), .ghrF(ghrF),
        .update_valid(update_valid), .pcE(pcE), .ghrE(ghrE),
        .local_predE(local_predE), .global_predE(global_predE),
        .predictedE(predictedE), .actual_taken(actual_taken),
        .mispredictE(mispredictE), .ready(ready),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc_f;
        logic        br_f, st_f, l_f, g_f;
        logic        uv, l_e, g_e, p_e, act;
        logic        exp_pred, exp_choice;
        logic [3:0]  exp_ghr;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic [31:0] pc_f, input logic br_f, st_f, l_f, g_f,
                                input logic uv, l_e, g_e, p_e, act,
                                input logic ep, ec, input logic [3:0] eg, input logic em);
        vec_t v;
        v.pc_f = pc_f; v.br_f = br_f; v.st_f = st_f; v.l_f = l_f; v.g_f = g_f;
        v.uv = uv; v.l_e = l_e; v.g_e = g_e; v.p_e = p_e; v.act = act;
        v.exp_pred = ep; v.exp_choice = ec; v.exp_ghr = eg; v.exp_mis = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    // Called at the negedge right after rst rises; expects INIT for 16 edges then RUN.
    task automatic run_init();
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("init_ready", ready, 0);
            chk("init_pred", predict_takenF, 0);
            chk("init_mis", mispredictE, 0);
            chk("init_ghr", ghrF, 0);
            @(posedge clk);
            @(negedge clk);
        end
        update_valid = 1'b0;
        #1;
        chk("run_ready", ready, 1);
        chk("run_choice", choiceF, 0);
        chk("run_pred", predict_takenF, 1);
        chk("init_br_frozen", br_count, 0);
        chk("init_mis_frozen", mispred_count, 0);
        branchF = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        pcF = 32'h40; pcE = 32'h40; ghrE = 4'h0;
        branchF = 0; stallF = 0; local_predF = 0; global_predF = 0;
        update_valid = 0; local_predE = 0; global_predE = 0; predictedE = 0; actual_taken = 0;
        rst = 1'b1;
        #2 rst = 1'b0;

        // pcF=pcE=0x40 with ghr 0 indexes entry 0; trained entry only ever 0.
        vecs[0]  = mk(32'h40, 0,0,0,1, 1,0,1,1,1, 0,0,4'h0,0);
        vecs[1]  = mk(32'h40, 0,0,0,1, 1,0,1,1,1, 0,1,4'h0,0);
        vecs[2]  = mk(32'h40, 1,1,0,1, 0,0,0,0,0, 1,1,4'h0,0);
        vecs[3]  = mk(32'h40, 0,0,0,1, 1,0,1,1,1, 0,1,4'h0,0);
        vecs[4]  = mk(32'h40, 0,0,0,1, 1,1,0,1,1, 0,1,4'h0,0);
        vecs[5]  = mk(32'h40, 0,0,0,1, 1,1,0,1,1, 0,1,4'h0,0);
        vecs[6]  = mk(32'h40, 0,0,0,1, 1,1,1,1,1, 0,0,4'h0,0);
        vecs[7]  = mk(32'h40, 0,0,0,1, 1,1,1,1,1, 0,0,4'h0,0);
        vecs[8]  = mk(32'h40, 0,0,0,1, 0,0,0,0,0, 0,0,4'h0,0);
        vecs[9]  = mk(32'h40, 1,0,1,0, 0,0,0,0,0, 1,0,4'h0,0);
        vecs[10] = mk(32'h40, 1,0,0,1, 0,0,0,0,0, 0,0,4'h1,0);
        vecs[11] = mk(32'h40, 1,0,1,0, 0,0,0,0,0, 1,0,4'h2,0);
        vecs[12] = mk(32'h40, 1,1,1,0, 0,0,0,0,0, 1,0,4'h5,0);
        vecs[13] = mk(32'h40, 0,0,1,0, 0,0,0,0,0, 0,0,4'h5,0);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_ghr", ghrF, 0);
        chk("rst_br", br_count, 0);
        chk("rst_mis", mispred_count, 0);
        chk("rst_pred", predict_takenF, 0);

        @(negedge clk);
        branchF = 1; local_predF = 1; update_valid = 1; predictedE = 1; actual_taken = 0;
        rst = 1'b1;
        run_init();

        for (int i = 0; i < 14; i++) begin
            pcF = vecs[i].pc_f; branchF = vecs[i].br_f; stallF = vecs[i].st_f;
            local_predF = vecs[i].l_f; global_predF = vecs[i].g_f;
            update_valid = vecs[i].uv; local_predE = vecs[i].l_e; global_predE = vecs[i].g_e;
            predictedE = vecs[i].p_e; actual_taken = vecs[i].act;
            pcE = 32'h40; ghrE = 4'h0;
            #1;
            chk($sformatf("v%0d_pred", i), predict_takenF, vecs[i].exp_pred);
            chk($sformatf("v%0d_choice", i), choiceF, vecs[i].exp_choice);
            chk($sformatf("v%0d_ghr", i), ghrF, vecs[i].exp_ghr);
            chk($sformatf("v%0d_mis", i), mispredictE, vecs[i].exp_mis);
            chk($sformatf("v%0d_ready", i), ready, 1);
            @(posedge clk);
            @(negedge clk);
        end

        // Seven resolved branches in the table, none mispredicted.
        branchF = 0; update_valid = 0; stallF = 0;
        #1;
        chk("pre_rst_ghr", ghrF, 4'h5);
        chk("pre_rst_br", br_count, 7);
        chk("pre_rst_mis", mispred_count, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_ghr", ghrF, 0);
        chk("mid_rst_br", br_count, 0);
        chk("mid_rst_mis", mispred_count, 0);
        @(negedge clk);
        pcF = 32'h40; branchF = 1; local_predF = 1; global_predF = 0;
        update_valid = 1; predictedE = 1; actual_taken = 0;
        rst = 1'b1;
        run_init();

        // Build GHR up to 1111 with four predicted-taken branches.
        branchF = 1; stallF = 0; local_predF = 1; global_predF = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fill_pred", predict_takenF, 1);
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("fill_ghr", ghrF, 4'hF);
        update_valid = 1; ghrE = 4'b0010; predictedE = 1; actual_taken = 0;
        local_predE = 0; global_predE = 0;
        #1;
        chk("rec_mis", mispredictE, 1);
        @(posedge clk);
        @(negedge clk);
        update_valid = 0; branchF = 0;
        #1;
        chk("rec_ghr", ghrF, 4'b0100);
        chk("rec_mis_cnt", mispred_count, 1);
        chk("rec_br_cnt", br_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tour_pred_ctrl.md
Name: tour_pred_ctrl

Overview:
Chooser controller for the tournament branch predictor in the 5-stage MIPS pipeline. It owns the choice pattern history table (CPHT) and the speculative global history register (GHR). In F it selects between the local and global predictor outputs. In E it trains the chooser, repairs the GHR on a mispredict and raises the flush request consumed by the hazard unit.

Parameters:
PHT_IDX_W, 10, log2 of CPHT entries (2-bit counters)
GHR_W, 8, global history length in bits; requires GHR_W <= PHT_IDX_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
pcF  in  32  fetch PC
branchF  in  1  predecoded: instruction in F is a conditional branch
stallF  in  1  fetch stall from hazard unit
local_predF  in  1  local predictor direction for pcF
global_predF  in  1  global predictor direction for pcF
predict_takenF  out  1  final predicted direction
choiceF  out  1  1 = global selected, 0 = local selected
ghrF  out  GHR_W  current speculative GHR, carried down the pipe with the branch
update_valid  in  1  branch resolved in E this cycle
pcE  in  32  PC of the resolving branch
ghrE  in  GHR_W  GHR snapshot taken when that branch was fetched
local_predE, global_predE, predictedE  in  1 each  directions recorded at fetch
actual_taken  in  1  resolved direction
mispredictE  out  1  flush request
ready  out  1  CPHT initialised
br_count, mispred_count  out  32 each  statistics

Behaviour:
- FSM states INIT and RUN. Asynchronous rst low forces:
  - state=INIT, init_idx=0, GHR=0, counters=0, ready=0.
  - This applies even mid-operation.
- INIT:
  - Each cycle writes CPHT[init_idx]=2'b01 (weakly local), then init_idx++.
  - After entry 2^PHT_IDX_W-1 is written, go to RUN next edge. INIT therefore lasts exactly 2^PHT_IDX_W cycles after rst rises.
  - ready=1 only in RUN.
  - In INIT: predict_takenF=0, choiceF=0, mispredictE=0, GHR frozen, update_valid ignored, statistics frozen.
- Index: idx = pc[PHT_IDX_W+1:2] XOR zero-extended GHR (ghrF in F, ghrE in E).
- Prediction (combinational, RUN only):
  - choiceF = CPHT[idxF][1].
  - predict_takenF = branchF & (choiceF ? global_predF : local_predF).
  - choiceF is valid regardless of branchF; predict_takenF=0 when branchF=0.
- mispredictE = ready & update_valid & (predictedE != actual_taken); combinational, same cycle as update_valid.
- GHR update (RUN, priority order):
  1. mispredictE: GHR <= {ghrE[GHR_W-2:0], actual_taken}. This overrides any F shift in the same cycle.
  2. else branchF & ~stallF: GHR <= {GHR[GHR_W-2:0], predict_takenF}.
  3. else hold.
- CPHT training (RUN, update_valid):
  - If local_predE == global_predE: no write.
  - Else if global_predE == actual_taken: counter++, saturating at 3.
  - Else: counter--, saturating at 0.
  - Write on the clock edge.
  - If the same-cycle F read hits the entry being written, F sees the pre-write value.
- Statistics: br_count increments on each update_valid in RUN; mispred_count increments on each mispredictE. Both saturate at 32'hFFFFFFFF. Reset to 0.
- Bench outputs are checked at negedge.

Test Plan:
- Init: PHT_IDX_W=4, GHR_W=4; release rst, hold branchF=1, local_predF=1. Expect ready=0 and predict_takenF=0 for 16 cycles. On cycle 17, ready=1, choiceF=0, predict_takenF=1.
- Chooser training: pcF=pcE=0x40, ghrE=0, local_predE=0, global_predE=1, actual_taken=1, update_valid for 2 cycles. Expect counter 01→10→11. Then with GHR=0, pcF=0x40, global_predF=1, local_predF=0: choiceF=1, predict_takenF=1. A third identical update stays at 11.
- Agreement: local_predE=global_predE=1, any actual_taken. Expect CPHT unchanged and choiceF unchanged.
- GHR shift/stall: from GHR=0, three fetched branches predicted 1,0,1 give ghrF=4'b0101. A branch with stallF=1 leaves ghrF unchanged.
- Recovery priority: ghrF=4'b1111 and ghrE=4'b0010; predictedE=1, actual_taken=0, update_valid=1, with branchF=1 and stallF=0 in the same cycle. Expect mispredictE=1, next ghrF=4'b0100, mispred_count=1, br_count=1.
- Mid-run reset: assert rst low during RUN with GHR≠0. Expect immediate ready=0, ghrF=0, counters 0, then a full 16-cycle INIT after release.
